// File: rtl/wordle_pkg.sv
// Shared types and constants for the Wordle tile renderer: board size,
// tile status encoding, 3:3:2 colour palette and the tile index helper.
package wordle_pkg;

  localparam int NROWS    = 6;
  localparam int NCOLS    = 5;
  localparam int NTILES   = NROWS * NCOLS;
  localparam int LETTER_W = 5;
  localparam int TILE_SZ  = 64;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ABSENT  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_CORRECT = 2'd3
  } status_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK        = '{r: 3'd0, g: 3'd0, b: 2'd0};
  localparam rgb_t C_WHITE        = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam rgb_t C_EMPTY_BORDER = '{r: 3'd2, g: 3'd2, b: 2'd1};
  localparam rgb_t C_ABSENT       = '{r: 3'd3, g: 3'd3, b: 2'd1};
  localparam rgb_t C_PRESENT      = '{r: 3'd6, g: 3'd5, b: 2'd0};
  localparam rgb_t C_CORRECT      = '{r: 3'd1, g: 3'd5, b: 2'd0};

  // Linear tile index row*5+col built from shifts and adds.
  function automatic logic [4:0] tile_index(input logic [2:0] row, input logic [2:0] col);
    return {row, 2'b00} + 5'(row) + 5'(col);
  endfunction

endpackage

// File: rtl/wordle_glyph_rom.sv
// 5x7 uppercase font. Combinational lookup of one glyph row; bit 4 is the
// leftmost pixel. Letter 0 and codes above 26 return an empty row.
module wordle_glyph_rom
  import wordle_pkg::*;
(
  input  logic [LETTER_W-1:0] letter,
  input  logic [2:0]          glyph_row,
  output logic [4:0]          bits
);

  logic [34:0] glyph;

  // Whole glyph for the letter, row 0 in the top five bits.
  always_comb begin
    glyph = '0;
    case (letter)
      5'd1:  glyph = 35'b01110_10001_10001_11111_10001_10001_10001; // A
      5'd2:  glyph = 35'b11110_10001_10001_11110_10001_10001_11110; // B
      5'd3:  glyph = 35'b01110_10001_10000_10000_10000_10001_01110; // C
      5'd4:  glyph = 35'b11100_10010_10001_10001_10001_10010_11100; // D
      5'd5:  glyph = 35'b11111_10000_10000_11110_10000_10000_11111; // E
      5'd6:  glyph = 35'b11111_10000_10000_11110_10000_10000_10000; // F
      5'd7:  glyph = 35'b01110_10001_10000_10111_10001_10001_01111; // G
      5'd8:  glyph = 35'b10001_10001_10001_11111_10001_10001_10001; // H
      5'd9:  glyph = 35'b01110_00100_00100_00100_00100_00100_01110; // I
      5'd10: glyph = 35'b00111_00010_00010_00010_00010_10010_01100; // J
      5'd11: glyph = 35'b10001_10010_10100_11000_10100_10010_10001; // K
      5'd12: glyph = 35'b10000_10000_10000_10000_10000_10000_11111; // L
      5'd13: glyph = 35'b10001_11011_10101_10101_10001_10001_10001; // M
      5'd14: glyph = 35'b10001_10001_11001_10101_10011_10001_10001; // N
      5'd15: glyph = 35'b01110_10001_10001_10001_10001_10001_01110; // O
      5'd16: glyph = 35'b11110_10001_10001_11110_10000_10000_10000; // P
      5'd17: glyph = 35'b01110_10001_10001_10001_10101_10010_01101; // Q
      5'd18: glyph = 35'b11110_10001_10001_11110_10100_10010_10001; // R
      5'd19: glyph = 35'b01111_10000_10000_01110_00001_00001_11110; // S
      5'd20: glyph = 35'b11111_00100_00100_00100_00100_00100_00100; // T
      5'd21: glyph = 35'b10001_10001_10001_10001_10001_10001_01110; // U
      5'd22: glyph = 35'b10001_10001_10001_10001_10001_01010_00100; // V
      5'd23: glyph = 35'b10001_10001_10001_10101_10101_10101_01010; // W
      5'd24: glyph = 35'b10001_10001_01010_00100_01010_10001_10001; // X
      5'd25: glyph = 35'b10001_10001_10001_01010_00100_00100_00100; // Y
      5'd26: glyph = 35'b11111_00001_00010_00100_01000_10000_11111; // Z
      default: glyph = '0;
    endcase
  end

  // Pick the requested row; row 7 is outside the font cell.
  always_comb begin
    bits = '0;
    case (glyph_row)
      3'd0: bits = glyph[34:30];
      3'd1: bits = glyph[29:25];
      3'd2: bits = glyph[24:20];
      3'd3: bits = glyph[19:15];
      3'd4: bits = glyph[14:10];
      3'd5: bits = glyph[9:5];
      3'd6: bits = glyph[4:0];
      default: bits = '0;
    endcase
  end

endmodule

// File: rtl/wordle_tile_renderer.sv
// Pixel colour source for the 640x480 Wordle display. Holds the 6x5 tile
// board and turns timing counters into 3:3:2 RGB over a 2-cycle pipeline,
// with hsync/vsync delayed to match.
module wordle_tile_renderer
  import wordle_pkg::*;
#(
  parameter int HBP       = 144,
  parameter int VBP       = 31,
  parameter int BOARD_X   = 160,
  parameter int BOARD_Y   = 48,
  parameter int BLINK_BIT = 4
) (
  input  logic       dclk,
  input  logic       clr_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [4:0] wr_letter,
  input  logic [1:0] wr_status,
  input  logic       clear_all,
  input  logic       cursor_en,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  localparam logic [9:0] H_ACT0 = 10'(HBP);
  localparam logic [9:0] H_ACT1 = 10'(HBP + 640);
  localparam logic [9:0] V_ACT0 = 10'(VBP);
  localparam logic [9:0] V_ACT1 = 10'(VBP + 480);
  localparam logic [9:0] H_BRD0 = 10'(HBP + BOARD_X);
  localparam logic [9:0] H_BRD1 = 10'(HBP + BOARD_X + NCOLS * TILE_SZ);
  localparam logic [9:0] V_BRD0 = 10'(VBP + BOARD_Y);
  localparam logic [9:0] V_BRD1 = 10'(VBP + BOARD_Y + NROWS * TILE_SZ);

  // ---------------- tile board ----------------
  logic [LETTER_W-1:0] tile_letter [NTILES];
  status_e             tile_status [NTILES];

  genvar gi;
  generate
    for (gi = 0; gi < NTILES; gi++) begin : g_tile
      localparam logic [2:0] TILE_ROW = 3'(gi / NCOLS);
      localparam logic [2:0] TILE_COL = 3'(gi % NCOLS);
      logic [LETTER_W-1:0] letter_reg;
      status_e             status_reg;

      // Tile storage: clear beats write; only an exact row/col match writes.
      always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
          letter_reg <= '0;
          status_reg <= ST_EMPTY;
        end else if (clear_all) begin
          letter_reg <= '0;
          status_reg <= ST_EMPTY;
        end else if (wr_en && wr_row == TILE_ROW && wr_col == TILE_COL) begin
          letter_reg <= wr_letter;
          status_reg <= status_e'(wr_status);
        end
      end

      assign tile_letter[gi] = letter_reg;
      assign tile_status[gi] = status_reg;
    end
  endgenerate

  // ---------------- frame counter ----------------
  logic       vsync_prev_reg;
  logic [7:0] frame_cnt_reg;

  // Count falling edges of raw vsync; drives the cursor blink.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vsync_prev_reg <= 1'b1;
      frame_cnt_reg  <= '0;
    end else begin
      vsync_prev_reg <= vsync_in;
      if (vsync_prev_reg && !vsync_in)
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  // ---------------- stage 1: geometry ----------------
  logic [8:0] bx, by;
  logic       active_c, in_board_c;

  assign bx = 9'(hc - H_BRD0);
  assign by = 9'(vc - V_BRD0);
  assign active_c   = (hc >= H_ACT0) && (hc < H_ACT1) && (vc >= V_ACT0) && (vc < V_ACT1);
  assign in_board_c = active_c && (hc >= H_BRD0) && (hc < H_BRD1) &&
                      (vc >= V_BRD0) && (vc < V_BRD1);

  logic       active_reg, in_board_reg, hs1_reg, vs1_reg;
  logic [2:0] row_reg, col_reg;
  logic [5:0] px_reg, py_reg;

  // Register position classification; row/col forced to 0 off-board so the
  // tile lookup index always stays within the board.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      active_reg   <= 1'b0;
      in_board_reg <= 1'b0;
      row_reg      <= '0;
      col_reg      <= '0;
      px_reg       <= '0;
      py_reg       <= '0;
      hs1_reg      <= 1'b1;
      vs1_reg      <= 1'b1;
    end else begin
      active_reg   <= active_c;
      in_board_reg <= in_board_c;
      row_reg      <= in_board_c ? by[8:6] : 3'd0;
      col_reg      <= in_board_c ? bx[8:6] : 3'd0;
      px_reg       <= bx[5:0];
      py_reg       <= by[5:0];
      hs1_reg      <= hsync_in;
      vs1_reg      <= vsync_in;
    end
  end

  // ---------------- stage 2: lookup and colour ----------------
  logic [4:0]          tile_idx;
  logic [LETTER_W-1:0] cur_letter;
  status_e             cur_status;
  logic [2:0]          glyph_row_c, glyph_col_c;
  logic [4:0]          glyph_bits;
  logic                in_glyph, glyph_on, gap, border, cursor_hit;

  assign tile_idx    = tile_index(row_reg, col_reg);
  assign cur_letter  = tile_letter[tile_idx];
  assign cur_status  = tile_status[tile_idx];
  assign glyph_row_c = 3'((py_reg - 6'd18) >> 2);
  assign glyph_col_c = 3'((px_reg - 6'd22) >> 2);
  assign in_glyph    = (px_reg >= 6'd22) && (px_reg <= 6'd41) &&
                       (py_reg >= 6'd18) && (py_reg <= 6'd45);
  assign glyph_on    = in_glyph && |(glyph_bits & (5'b10000 >> glyph_col_c));
  assign gap         = (px_reg < 6'd2) || (px_reg > 6'd61) || (py_reg < 6'd2) || (py_reg > 6'd61);
  assign border      = (px_reg < 6'd5) || (px_reg > 6'd58) || (py_reg < 6'd5) || (py_reg > 6'd58);
  assign cursor_hit  = cursor_en && (row_reg == cur_row) && (col_reg == cur_col) &&
                       !frame_cnt_reg[BLINK_BIT];

  wordle_glyph_rom u_glyph_rom (
    .letter    (cur_letter),
    .glyph_row (glyph_row_c),
    .bits      (glyph_bits)
  );

  rgb_t fill_col, border_col, pix_next;

  // Status palette: empty tiles have a dim border and black interior.
  always_comb begin
    fill_col   = C_BLACK;
    border_col = C_EMPTY_BORDER;
    case (cur_status)
      ST_ABSENT:  begin fill_col = C_ABSENT;  border_col = C_ABSENT;  end
      ST_PRESENT: begin fill_col = C_PRESENT; border_col = C_PRESENT; end
      ST_CORRECT: begin fill_col = C_CORRECT; border_col = C_CORRECT; end
      default:    begin fill_col = C_BLACK;   border_col = C_EMPTY_BORDER; end
    endcase
  end

  // Pixel priority: off-board/gap black, glyph white, border (cursor), fill.
  always_comb begin
    pix_next = C_BLACK;
    if (active_reg && in_board_reg && !gap) begin
      if (glyph_on)
        pix_next = C_WHITE;
      else if (border)
        pix_next = cursor_hit ? C_WHITE : border_col;
      else
        pix_next = fill_col;
    end
  end

  // Output registers: colour and the second sync delay stage.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      red   <= pix_next.r;
      green <= pix_next.g;
      blue  <= pix_next.b;
      hsync <= hs1_reg;
      vsync <= vs1_reg;
    end
  end

endmodule

// File: tb/tb_wordle_tile_renderer.sv
// Bench for wordle_tile_renderer: every driven cycle pushes its expected
// {rgb, hsync, vsync} to a scoreboard, popped and compared two clocks later.
module tb_wordle_tile_renderer;

  localparam int HBP = 144;
  localparam int VBP = 31;

  localparam logic [7:0] BLK = 8'h00;
  localparam logic [7:0] WHI = 8'hFF;
  localparam logic [7:0] EMB = 8'h49; // 2,2,1
  localparam logic [7:0] ABS = 8'h6D; // 3,3,1
  localparam logic [7:0] PRE = 8'hD4; // 6,5,0
  localparam logic [7:0] COR = 8'h34; // 1,5,0

  logic       dclk, clr_n;
  logic [9:0] hc, vc;
  logic       hsync_in, vsync_in, wr_en, clear_all, cursor_en;
  logic [2:0] wr_row, wr_col, cur_row, cur_col;
  logic [4:0] wr_letter;
  logic [1:0] wr_status;
  logic       hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;

  wordle_tile_renderer dut (
    .dclk(dclk), .clr_n(clr_n), .hc(hc), .vc(vc),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_letter(wr_letter), .wr_status(wr_status), .clear_all(clear_all),
    .cursor_en(cursor_en), .cur_row(cur_row), .cur_col(cur_col),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  initial dclk = 1'b0;
  always #20 dclk = ~dclk;

  typedef struct {
    int          due;
    logic [9:0]  exp;
    string       name;
  } sb_t;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  int   neg_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  logic       nx_wr = 1'b0, nx_clr = 1'b0;
  logic [2:0] nx_row = '0, nx_col = '0;
  logic [4:0] nx_letter = '0;
  logic [1:0] nx_status = '0;

  vec_t t_fresh[5];
  vec_t t_main[19];
  vec_t t_clear[6];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rgb/hs/vs=%h required %h", name, act, exp);
    end else begin
      $display("ok   %s: rgb/hs/vs=%h", name, act);
    end
  endtask

  // Scoreboard consumer: outputs are sampled on the falling edge.
  always @(negedge dclk) begin
    neg_cnt++;
    while (sbq.size() > 0 && sbq[0].due <= neg_cnt) begin
      mon_e = sbq.pop_front();
      chk(mon_e.name, {red, green, blue, hsync, vsync}, mon_e.exp);
    end
  end

  function automatic int tx(input int c, input int p);
    return 160 + 64 * c + p;
  endfunction

  function automatic int ty(input int r, input int p);
    return 48 + 64 * r + p;
  endfunction

  task automatic step(input int h, input int v, input logic hs, input logic vs,
                      input logic [7:0] rgb, input string name);
    sb_t e;
    @(negedge dclk);
    #1;
    hc        = 10'(h);
    vc        = 10'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    wr_en     = nx_wr;
    wr_row    = nx_row;
    wr_col    = nx_col;
    wr_letter = nx_letter;
    wr_status = nx_status;
    clear_all = nx_clr;
    nx_wr     = 1'b0;
    nx_clr    = 1'b0;
    e.due  = neg_cnt + 2;
    e.exp  = {rgb, hs, vs};
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] rgb, input string name);
    step(HBP + x, VBP + y, 1'b1, 1'b1, rgb, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b1, 1'b1, BLK, "idle");
  endtask

  task automatic set_wr(input int r, input int c, input int l, input int s);
    nx_wr     = 1'b1;
    nx_row    = 3'(r);
    nx_col    = 3'(c);
    nx_letter = 5'(l);
    nx_status = 2'(s);
  endtask

  task automatic wr(input int r, input int c, input int l, input int s);
    set_wr(r, c, l, s);
    step(0, 0, 1'b1, 1'b1, BLK, "wr");
  endtask

  task automatic run_table(input vec_t t[]);
    foreach (t[i]) pix(t[i].x, t[i].y, t[i].exp, t[i].name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    t_fresh[0] = '{tx(0, 30), ty(0, 30), BLK, "fresh_empty_int"};
    t_fresh[1] = '{tx(0, 2),  ty(0, 30), EMB, "fresh_empty_border"};
    t_fresh[2] = '{tx(4, 61), ty(5, 30), EMB, "fresh_border_px61"};
    t_fresh[3] = '{tx(2, 4),  ty(2, 4),  EMB, "fresh_border_px4"};
    t_fresh[4] = '{10,        10,        BLK, "fresh_off_board"};

    t_main[0]  = '{tx(0, 10), ty(0, 10), COR, "c00_int"};
    t_main[1]  = '{tx(0, 30), ty(0, 18), WHI, "A_row0_col2"};
    t_main[2]  = '{tx(0, 22), ty(0, 18), COR, "A_row0_col0_clear"};
    t_main[3]  = '{tx(0, 38), ty(0, 42), WHI, "A_row6_col4"};
    t_main[4]  = '{tx(0, 42), ty(0, 18), COR, "glyph_right_edge"};
    t_main[5]  = '{tx(0, 30), ty(0, 46), COR, "glyph_below"};
    t_main[6]  = '{tx(0, 3),  ty(0, 30), COR, "c00_border"};
    t_main[7]  = '{tx(0, 1),  ty(0, 30), BLK, "c00_gap"};
    t_main[8]  = '{tx(0, 63), ty(0, 63), BLK, "c00_gap_corner"};
    t_main[9]  = '{tx(4, 30), ty(5, 30), PRE, "c54_int"};
    t_main[10] = '{tx(4, 60), ty(5, 60), PRE, "c54_border"};
    t_main[11] = '{tx(1, 30), ty(0, 18), ABS, "letter27_blank"};
    t_main[12] = '{tx(2, 22), ty(0, 18), WHI, "Z_row0_col0"};
    t_main[13] = '{tx(2, 38), ty(0, 22), WHI, "Z_row1_col4"};
    t_main[14] = '{tx(2, 22), ty(0, 22), ABS, "Z_row1_col0_clear"};
    t_main[15] = '{tx(0, 30), ty(1, 30), BLK, "no_alias_r1c0"};
    t_main[16] = '{tx(0, 3),  ty(1, 30), EMB, "no_alias_r1c0_border"};
    t_main[17] = '{tx(4, 30), ty(0, 30), BLK, "c04_int"};
    t_main[18] = '{639,       479,       BLK, "active_corner"};

    t_clear[0] = '{tx(0, 30), ty(0, 30), BLK, "clr_c00_int"};
    t_clear[1] = '{tx(0, 30), ty(0, 18), BLK, "clr_c00_glyph"};
    t_clear[2] = '{tx(4, 30), ty(5, 30), BLK, "clr_c54_int"};
    t_clear[3] = '{tx(2, 3),  ty(2, 30), EMB, "clr_c22_border"};
    t_clear[4] = '{tx(2, 30), ty(2, 30), BLK, "clr_c22_int"};
    t_clear[5] = '{tx(2, 22), ty(0, 18), BLK, "clr_c02_glyph"};

    // Reset: sync outputs high and colour zero regardless of inputs.
    clr_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    hc = 10'(HBP + 162); vc = 10'(VBP + 78);
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_letter = '0; wr_status = '0;
    clear_all = 1'b0; cursor_en = 1'b0; cur_row = '0; cur_col = '0;
    repeat (3) @(negedge dclk);
    chk("reset_state", {red, green, blue, hsync, vsync}, 10'b00000000_1_1);
    hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge dclk);
    #1 clr_n = 1'b1;

    run_table(t_fresh);

    wr(0, 0, 1, 3);
    wr(5, 4, 0, 2);
    wr(0, 1, 27, 1);
    wr(0, 2, 26, 1);
    wr(6, 0, 5, 1);
    wr(0, 5, 5, 1);
    wr(7, 7, 5, 3);
    run_table(t_main);

    // Raw counters outside the legal range are inactive.
    step(800, 100, 1'b1, 1'b1, BLK, "hc_800");
    step(1023, 300, 1'b1, 1'b1, BLK, "hc_1023");
    step(400, 521, 1'b1, 1'b1, BLK, "vc_521");
    step(400, 1023, 1'b1, 1'b1, BLK, "vc_1023");

    // A write lands before the stage-2 lookup of the pixel driven with it.
    set_wr(2, 2, 0, 1);
    pix(tx(2, 30), ty(2, 30), ABS, "wr_same_cycle");

    // clear_all beats a simultaneous write.
    nx_clr = 1'b1;
    set_wr(2, 2, 0, 1);
    step(0, 0, 1'b1, 1'b1, BLK, "clear_and_wr");
    run_table(t_clear);

    // Cursor blink on tile (1,3).
    wr(1, 3, 0, 2);
    idle(2);
    cursor_en = 1'b1; cur_row = 3'd1; cur_col = 3'd3;
    pix(tx(3, 3),  ty(1, 30), WHI, "cur_border_on");
    pix(tx(3, 30), ty(1, 60), WHI, "cur_border_bottom_on");
    pix(tx(3, 30), ty(1, 30), PRE, "cur_int");
    pix(tx(2, 3),  ty(1, 30), EMB, "cur_other_tile");
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1'b1, 1'b0, BLK, "vs_low");
      step(0, 0, 1'b1, 1'b1, BLK, "vs_high");
    end
    pix(tx(3, 3), ty(1, 30), PRE, "cur_blink_off");
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1'b1, 1'b0, BLK, "vs_low");
      step(0, 0, 1'b1, 1'b1, BLK, "vs_high");
    end
    pix(tx(3, 3), ty(1, 30), WHI, "cur_blink_on_again");
    idle(2);
    cur_row = 3'd6;
    pix(tx(3, 3), ty(1, 30), PRE, "cur_out_of_range");
    idle(2);
    cur_row = 3'd1; cursor_en = 1'b0;
    pix(tx(3, 3), ty(1, 30), PRE, "cur_disabled");

    // Sync pass-through with hc=0 or vc=0 (inactive, colour zero).
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0)
        step(0, int'($urandom_range(0, 520)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), BLK, "sync_hc0");
      else
        step(int'($urandom_range(0, 799)), 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), BLK, "sync_vc0");
    end

    idle(1);
    repeat (4) @(negedge dclk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wordle_tile_renderer.md
Name: wordle_tile_renderer

Overview:
- Pixel-colour source for the 640x480 VGA timing generator in the Wordle display path.
- Holds the 6-row x 5-column tile board (letter + status per tile), written by game logic through a simple write port.
- Converts raw timing counters (hc, vc) into 3:3:2 RGB through a fixed 2-cycle pipeline.
- Delays hsync/vsync by the same 2 cycles so colour and sync stay aligned at the pins.

Parameters:
- HBP, 144, hc value of first active pixel
- VBP, 31, vc value of first active line
- BOARD_X, 160, active-area x of board left edge
- BOARD_Y, 48, active-area y of board top edge
- BLINK_BIT, 4, frame-counter bit that sets cursor blink period (2^BLINK_BIT frames per phase)

Ports:
- dclk  in  1  25 MHz pixel clock
- clr_n  in  1  asynchronous active-low reset
- hc  in  10  horizontal counter from timing generator, 0..799
- vc  in  10  vertical counter from timing generator, 0..520
- hsync_in  in  1  raw hsync from timing generator
- vsync_in  in  1  raw vsync from timing generator
- wr_en  in  1  tile write strobe, one tile per cycle
- wr_row  in  3  target row, 0..5
- wr_col  in  3  target column, 0..4
- wr_letter  in  5  0 = blank, 1..26 = A..Z
- wr_status  in  2  0 empty, 1 absent, 2 present, 3 correct
- clear_all  in  1  single-cycle pulse; blanks the whole board
- cursor_en  in  1  enable cursor highlight
- cur_row  in  3  cursor tile row
- cur_col  in  3  cursor tile column
- hsync  out  1  hsync_in delayed 2 cycles
- vsync  out  1  vsync_in delayed 2 cycles
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue

Behaviour:
- Reset (clr_n low, async): all 30 tiles set to letter 0 / status 0; pipeline registers, frame counter, red/green/blue cleared to 0; hsync/vsync outputs and delay registers set to 1.
- Geometry:
  - x = hc-HBP, y = vc-VBP; active when 0<=x<640 and 0<=y<480.
  - Board area: BOARD_X<=x<BOARD_X+320 and BOARD_Y<=y<BOARD_Y+384.
  - Tile size 64x64. col = (x-BOARD_X)>>6, row = (y-BOARD_Y)>>6. Shifts only, no dividers.
  - Tile-local coordinates: px = (x-BOARD_X)[5:0], py = (y-BOARD_Y)[5:0].
- Stage 1 (registered): active, in_board, row, col, px, py, hsync/vsync delay 1.
- Stage 2 (registered): tile lookup, glyph ROM read, colour select. Drives red/green/blue, hsync, vsync. Output at edge N+2 corresponds to hc/vc sampled at edge N.
- Tile layout in px/py:
  - Gap: px or py in 0..1 or 62..63; colour black.
  - Border: px or py in 2..4 or 59..61, excluding gap.
  - Interior: everything else.
- Colours (R,G,B):
  - Black 0,0,0; white 7,7,3.
  - Empty: border 2,2,1, interior black.
  - Absent: 3,3,1 on border and interior.
  - Present: 6,5,0 on border and interior.
  - Correct: 1,5,0 on border and interior.
- Glyph:
  - 5x7 font scaled x4, occupying px 22..41, py 18..45.
  - Glyph row = (py-18)>>2, glyph column = (px-22)>>2.
  - Set glyph bit forces white; letter 0 draws nothing. Letter codes 27..31 draw nothing.
- Cursor:
  - Border forced white when cursor_en, (row,col)==(cur_row,cur_col), and frame_cnt[BLINK_BIT]==0.
  - Out-of-range cursor draws nothing.
- Frame counter: 8-bit, increments on each falling edge of vsync_in (detected against a registered copy), wraps 255->0.
- Outside board but active: black. Outside active: 0 on all colour outputs.
- Writes:
  - On a dclk edge with wr_en=1 and row<=5, col<=4: the tile takes wr_letter/wr_status.
  - Out-of-range writes are ignored with no side effects.
  - Takes effect for pixels whose stage-2 lookup occurs after that edge; no frame-level double buffering.
- clear_all=1 blanks all tiles on that edge. clear_all wins over a simultaneous wr_en.
- hc/vc beyond legal range (hc>=800 or vc>=521) are treated as inactive: black output.

Decomposition:
- Shared package wordle_pkg:
  - Status encoding constants ST_EMPTY/ST_ABSENT/ST_PRESENT/ST_CORRECT.
  - Board dims NROWS=6, NCOLS=5.
  - Letter-code width 5.
  - Colour constants above.
- One sub-module: wordle_glyph_rom. Combinational; inputs letter[4:0], glyph_row[2:0]; output bits[4:0], MSB = leftmost pixel.

Test Plan:
- Reset release, hc=144+160+30, vc=31+48+30 -> two cycles later RGB=0,0,0 (empty interior); hc=144+162, same vc -> border 2,2,1; hsync/vsync=1 during reset.
- Write row0 col0 letter 1 ('A') status 3, then sample px=10,py=10 -> 1,5,0; sample a known set pixel of 'A' -> 7,7,3; output appears exactly 2 cycles after hc/vc.
- Write row 5 col 4 status 2 -> tile at x=416..479, y=368..431 interior 6,5,0; write row 6 or col 5 -> no tile changes.
- clear_all and wr_en (row2 col2 status1) asserted in the same cycle -> all tiles empty, row2 col2 border 2,2,1.
- cursor_en=1, cur=(1,3) -> border white for frames 0..15, status-colour border for frames 16..31 (16 vsync falling edges per phase).
- hsync_in/vsync_in toggle pattern -> hsync/vsync reproduce it delayed exactly 2 dclk; hc=0 or vc=0 -> RGB 0.
